// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB,
// load-use bubble insertion and a saturating count of ID stall cycles.
module id_ex_stage #(
    parameter int unsigned data_width = 32,
    parameter int unsigned reg_addr_w = 5,
    parameter int unsigned cnt_width  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [data_width-1:0] id_pc,
    input  logic [reg_addr_w-1:0] id_rs1_addr,
    input  logic [reg_addr_w-1:0] id_rs2_addr,
    input  logic [reg_addr_w-1:0] id_rd_addr,
    input  logic [data_width-1:0] id_rs1_data,
    input  logic [data_width-1:0] id_rs2_data,
    input  logic [data_width-1:0] id_imm,
    input  logic [5:0]            id_alu_control,
    input  logic                  id_alu_src_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic [reg_addr_w-1:0] exm_rd_addr,
    input  logic                  exm_reg_write,
    input  logic [data_width-1:0] exm_result,
    input  logic [reg_addr_w-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic [data_width-1:0] wb_result,
    input  logic                  flush,
    input  logic                  stall_in,
    output logic [5:0]            ALU_Control,
    output logic [data_width-1:0] operand_A,
    output logic [data_width-1:0] operand_B,
    output logic                  ex_valid,
    output logic [data_width-1:0] ex_pc,
    output logic [reg_addr_w-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [data_width-1:0] ex_store_data,
    output logic                  id_stall,
    output logic [cnt_width-1:0]  stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [data_width-1:0] pc;
        logic [reg_addr_w-1:0] rs1_addr;
        logic [reg_addr_w-1:0] rs2_addr;
        logic [reg_addr_w-1:0] rd_addr;
        logic [data_width-1:0] rs1_data;
        logic [data_width-1:0] rs2_data;
        logic [data_width-1:0] imm;
        logic [5:0]            alu_control;
        logic                  alu_src_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_regs_t;

    ex_regs_t              ex_q, ex_d, id_fields;
    logic [cnt_width-1:0]  stall_count_q, stall_count_d;
    logic                  load_use;
    logic                  stall_c;
    logic [data_width-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        id_fields = '{valid:       id_valid,
                      pc:          id_pc,
                      rs1_addr:    id_rs1_addr,
                      rs2_addr:    id_rs2_addr,
                      rd_addr:     id_rd_addr,
                      rs1_data:    id_rs1_data,
                      rs2_data:    id_rs2_data,
                      imm:         id_imm,
                      alu_control: id_alu_control,
                      alu_src_imm: id_alu_src_imm,
                      reg_write:   id_reg_write,
                      mem_read:    id_mem_read,
                      mem_write:   id_mem_write};

        load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) & id_valid &
                   ((id_rs1_addr == ex_q.rd_addr) | (id_rs2_addr == ex_q.rd_addr));
        // rst_n gating keeps id_stall low while reset is held even if stall_in is high
        stall_c  = rst_n & ~flush & (load_use | stall_in);

        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall_in) begin
            if (load_use || !id_valid) begin
                ex_d = '0;
            end else begin
                ex_d = id_fields;
            end
        end

        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + {{(cnt_width-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        if (ex_q.rs1_addr == '0) begin
            fwd_rs1 = '0;
        end else if (exm_reg_write && (exm_rd_addr == ex_q.rs1_addr)) begin
            fwd_rs1 = exm_result;
        end else if (wb_reg_write && (wb_rd_addr == ex_q.rs1_addr)) begin
            fwd_rs1 = wb_result;
        end

        fwd_rs2 = ex_q.rs2_data;
        if (ex_q.rs2_addr == '0) begin
            fwd_rs2 = '0;
        end else if (exm_reg_write && (exm_rd_addr == ex_q.rs2_addr)) begin
            fwd_rs2 = exm_result;
        end else if (wb_reg_write && (wb_rd_addr == ex_q.rs2_addr)) begin
            fwd_rs2 = wb_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ALU_Control   = ex_q.alu_control;
    assign operand_A     = fwd_rs1;
    assign operand_B     = ex_q.alu_src_imm ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_rd_addr    = ex_q.rd_addr;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign id_stall      = stall_c;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle reference model of the EX slot
// plus literal checks of the forwarding, stall, flush and reset scenarios.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [5:0]  id_alu_control;
    logic        id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  exm_rd_addr, wb_rd_addr;
    logic        exm_reg_write, wb_reg_write;
    logic [31:0] exm_result, wb_result;
    logic        flush, stall_in;

    logic [5:0]  ALU_Control;
    logic [31:0] operand_A, operand_B, ex_pc, ex_store_data;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_stall;
    logic [4:0]  ex_rd_addr;
    logic [31:0] stall_count;

    logic [5:0]  ALU_Control4;
    logic [31:0] operand_A4, operand_B4, ex_pc4, ex_store_data4;
    logic        ex_valid4, ex_reg_write4, ex_mem_read4, ex_mem_write4, id_stall4;
    logic [4:0]  ex_rd_addr4;
    logic [3:0]  stall_count4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_control(id_alu_control), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .flush(flush), .stall_in(stall_in),
        .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .id_stall(id_stall), .stall_count(stall_count)
    );

    id_ex_stage #(.data_width(32), .reg_addr_w(5), .cnt_width(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_control(id_alu_control), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exm_rd_addr(exm_rd_addr), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .flush(flush), .stall_in(stall_in),
        .ALU_Control(ALU_Control4), .operand_A(operand_A4), .operand_B(operand_B4),
        .ex_valid(ex_valid4), .ex_pc(ex_pc4), .ex_rd_addr(ex_rd_addr4),
        .ex_reg_write(ex_reg_write4), .ex_mem_read(ex_mem_read4), .ex_mem_write(ex_mem_write4),
        .ex_store_data(ex_store_data4), .id_stall(id_stall4), .stall_count(stall_count4)
    );

    // Reference: the instruction sitting in EX, as a plain record.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [5:0]  ctl;
        logic        srcimm, rw, mr, mw;
    } instr_t;

    instr_t      m;
    logic [31:0] mcnt;
    logic [3:0]  mcnt4;

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0)                              return 32'd0;
        if (exm_reg_write && exm_rd_addr == a)      return exm_result;
        if (wb_reg_write && wb_rd_addr == a)        return wb_result;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        return m.valid && m.mr && m.rd != 5'd0 && id_valid &&
               (id_rs1_addr == m.rd || id_rs2_addr == m.rd);
    endfunction

    function automatic logic ref_stall();
        return rst_n && !flush && (ref_hazard() || stall_in);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= '0;
            mcnt  <= 32'd0;
            mcnt4 <= 4'd0;
        end else begin
            if (flush)
                m <= '0;
            else if (!stall_in) begin
                if (!id_valid || ref_hazard())
                    m <= '0;
                else
                    m <= '{id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
                           id_rs1_data, id_rs2_data, id_imm, id_alu_control,
                           id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write};
            end
            if (ref_stall()) begin
                if (mcnt != 32'hFFFF_FFFF) mcnt <= mcnt + 32'd1;
                if (mcnt4 != 4'd15)        mcnt4 <= mcnt4 + 4'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ex_valid",      {31'd0, ex_valid},     {31'd0, m.valid});
        chk("ex_pc",         ex_pc,                 m.pc);
        chk("ex_rd_addr",    {27'd0, ex_rd_addr},   {27'd0, m.rd});
        chk("ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, m.rw});
        chk("ex_mem_read",   {31'd0, ex_mem_read},  {31'd0, m.mr});
        chk("ex_mem_write",  {31'd0, ex_mem_write}, {31'd0, m.mw});
        chk("ALU_Control",   {26'd0, ALU_Control},  {26'd0, m.ctl});
        chk("operand_A",     operand_A,             ref_read(m.rs1, m.d1));
        chk("operand_B",     operand_B,             m.srcimm ? m.imm : ref_read(m.rs2, m.d2));
        chk("ex_store_data", ex_store_data,         ref_read(m.rs2, m.d2));
        chk("id_stall",      {31'd0, id_stall},     {31'd0, ref_stall()});
        chk("stall_count",   stall_count,           mcnt);
        chk("id_stall4",     {31'd0, id_stall4},    {31'd0, ref_stall()});
        chk("stall_count4",  {28'd0, stall_count4}, {28'd0, mcnt4});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [5:0] ctl, input logic srcimm,
                         input logic rw, input logic mr, input logic mw);
        id_valid = 1'b1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_control = ctl;
        id_alu_src_imm = srcimm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_control = 0;
        id_alu_src_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exm_rd_addr = 0; exm_reg_write = 0; exm_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
        flush = 0; stall_in = 0;
        #12 rst_n = 1'b1;

        // EX/MEM forwarding into both sources
        step();
        issue(32'h100, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        issue(32'h104, 5'd3, 5'd3, 5'd4, 32'hDEAD, 32'hDEAD, 32'h0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        exm_rd_addr = 5'd3; exm_reg_write = 1'b1; exm_result = 32'h55;
        issue(32'h108, 5'd5, 5'd5, 5'd8, 32'h77, 32'h66, 32'h1234, 6'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t2_opA", operand_A, 32'h55);
        chk("t2_opB", operand_B, 32'h55);
        chk("t2_pc",  ex_pc, 32'h104);

        // forwarding priority, immediate select, x0 destination
        step();
        exm_rd_addr = 5'd5; exm_reg_write = 1'b1; exm_result = 32'h11;
        wb_rd_addr  = 5'd5; wb_reg_write  = 1'b1; wb_result  = 32'h22;
        #1;
        chk("t3_opA_exm", operand_A, 32'h11);
        chk("t3_opB_imm", operand_B, 32'h1234);
        chk("t3_store",   ex_store_data, 32'h11);
        chk("t3_alu",     {26'd0, ALU_Control}, 32'h0A);
        exm_reg_write = 1'b0;
        #1;
        chk("t3_opA_wb", operand_A, 32'h22);
        exm_rd_addr = 5'd0; exm_reg_write = 1'b1; exm_result = 32'h99; wb_reg_write = 1'b0;
        #1;
        chk("t3_opA_rf", operand_A, 32'h77);
        chk("t3_store_rf", ex_store_data, 32'h66);
        issue(32'h10C, 5'd0, 5'd0, 5'd9, 32'h33, 32'h44, 32'h0, 6'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        wb_rd_addr = 5'd0; wb_reg_write = 1'b1; wb_result = 32'h22;
        #1;
        chk("t3_x0_A", operand_A, 32'h0);
        chk("t3_x0_B", operand_B, 32'h0);

        // load-use: one bubble, then MEM/WB supplies the load value
        exm_reg_write = 1'b0; wb_reg_write = 1'b0;
        issue(32'h200, 5'd1, 5'd0, 5'd6, 32'h1000, 32'h0, 32'h4, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        issue(32'h204, 5'd6, 5'd1, 5'd7, 32'hBAD, 32'h10, 32'h0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t4_stall", {31'd0, id_stall}, 32'd1);
        step();
        chk("t4_bubble", {31'd0, ex_valid}, 32'd0);
        chk("t4_unstall", {31'd0, id_stall}, 32'd0);
        step();
        wb_rd_addr = 5'd6; wb_reg_write = 1'b1; wb_result = 32'hCAFE;
        #1;
        chk("t4_opA_wb", operand_A, 32'hCAFE);
        chk("t4_opB",    operand_B, 32'h10);
        chk("t4_pc",     ex_pc, 32'h204);
        chk("t4_count",  stall_count, 32'd1);

        // flush beats stall_in and load-use
        wb_reg_write = 1'b0;
        issue(32'h208, 5'd1, 5'd0, 5'd6, 32'h1000, 32'h0, 32'h8, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        issue(32'h20C, 5'd6, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1; stall_in = 1'b1;
        #1;
        chk("t5_stall", {31'd0, id_stall}, 32'd0);
        step();
        flush = 1'b0; stall_in = 1'b0;
        chk("t5_bubble", {31'd0, ex_valid}, 32'd0);
        chk("t5_count",  stall_count, 32'd1);

        // back-end freeze holds EX; counters, including 4-bit saturation
        issue(32'h300, 5'd2, 5'd0, 5'd9, 32'h5, 32'h0, 32'h0, 6'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        issue(32'h400, 5'd3, 5'd0, 5'd10, 32'h6, 32'h0, 32'h0, 6'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_hold_pc", ex_pc, 32'h300);
        end
        chk("t6_count", stall_count, 32'd4);
        stall_in = 1'b0;
        step();
        chk("t6_release_pc", ex_pc, 32'h400);
        stall_in = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("t6_count32", stall_count, 32'd24);
        chk("t6_sat4", {28'd0, stall_count4}, 32'd15);
        stall_in = 1'b0;

        // asynchronous reset mid-stall
        step();
        stall_in = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("t1_valid", {31'd0, ex_valid}, 32'd0);
        chk("t1_opA",   operand_A, 32'd0);
        chk("t1_count", stall_count, 32'd0);
        chk("t1_stall", {31'd0, id_stall}, 32'd0);
        stall_in = 1'b0; id_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();
        chk("t1_post_valid", {31'd0, ex_valid}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
